basket_controller: RTL and testbench

- Holds the shopping basket: up to 8 slots, each a (ProductID, quantity) pair.
- Responds to the terminal state machine's one-cycle command pulses:
  - Enable adds a product and quantity.
  - Cancel removes the entry at a cursor index.
  - Clear empties the basket.
- Reports the live entry count back to the state machine.
- Provides a registered read port for the VGA/highlight path.

---
 rtl/basket_controller.sv | 187 ++++++++++++++++++
 tb/tb_basket_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/basket_controller.sv
// basket_controller: shopping basket of MAX_ITEMS (ProductID, quantity) slots,
// driven by one-cycle Enable/Cancel/Clear pulses from the terminal FSM.
// Optional feature macro BASKET_MERGE_EN: adds a SEARCH state so that a
// repeated ProductID merges into its existing slot with a saturating quantity.
// Without it every add appends a new slot.
module basket_controller #(
  parameter int MAX_ITEMS = 8,
  parameter int MAX_QTY   = 15
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       Enable_Pulse,
  input  logic       Cancel_Pulse,
  input  logic       Clear_Pulse,
  input  logic [3:0] ProductID_in,
  input  logic [3:0] ProductQuantity_in,
  input  logic [2:0] Read_Index,
  output logic [3:0] BasketProductNum,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic       Full,
  output logic [3:0] Read_ProductID,
  output logic [3:0] Read_Quantity
);
  localparam int         IW   = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
  localparam logic [3:0] NMAX = 4'(MAX_ITEMS);
  localparam logic [4:0] QMAX = 5'(MAX_QTY);

`ifdef BASKET_MERGE_EN
  typedef enum logic [1:0] {IDLE, SEARCH, APPEND, REMOVE} state_t;
`else
  typedef enum logic [1:0] {IDLE, APPEND, REMOVE} state_t;
`endif

  state_t        state_q;
  logic [3:0]    id_q  [MAX_ITEMS];
  logic [3:0]    qty_q [MAX_ITEMS];
  logic [3:0]    cnt_q, idx_q, lid_q, lqty_q;
  logic          busy_q, done_q, err_q;
  logic [3:0]    rd_id_q, rd_qty_q;
  logic [IW-1:0] cur, nxt, tail, rsel;
`ifdef BASKET_MERGE_EN
  logic [4:0]    sum;
`endif

  // Quantities are summed one bit wider, then pinned at MAX_QTY (no wrap)
  function automatic logic [3:0] clamp(input logic [4:0] v);
    return (v > QMAX) ? QMAX[3:0] : v[3:0];
  endfunction

  // Slot selectors: scan/compact pointer and its successor, append tail, read port
  always_comb begin
    cur  = idx_q[IW-1:0];
    nxt  = cur + IW'(1);
    tail = cnt_q[IW-1:0];
    rsel = IW'(Read_Index);
`ifdef BASKET_MERGE_EN
    sum  = {1'b0, qty_q[cur]} + {1'b0, lqty_q};
`endif
  end

  // Command FSM: owns slot storage, count, status pulses and the read register
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      lid_q    <= '0;
      lqty_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_id_q  <= '0;
      rd_qty_q <= '0;
      for (int i = 0; i < MAX_ITEMS; i++) begin
        id_q[i]  <= '0;
        qty_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Unoccupied slots always read as 0/0
      if ({1'b0, Read_Index} < cnt_q) begin
        rd_id_q  <= id_q[rsel];
        rd_qty_q <= qty_q[rsel];
      end else begin
        rd_id_q  <= '0;
        rd_qty_q <= '0;
      end
      if (Clear_Pulse) begin
        // Clear wins everywhere; wiping every slot also discards a half-done compaction
        for (int i = 0; i < MAX_ITEMS; i++) begin
          id_q[i]  <= '0;
          qty_q[i] <= '0;
        end
        cnt_q   <= '0;
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        err_q   <= Enable_Pulse | Cancel_Pulse;
      end else if (state_q == IDLE) begin
        if (Cancel_Pulse) begin
          if (ProductID_in >= cnt_q) begin
            err_q <= 1'b1;
          end else begin
            idx_q   <= ProductID_in;
            state_q <= REMOVE;
            busy_q  <= 1'b1;
            err_q   <= Enable_Pulse;
          end
        end else if (Enable_Pulse) begin
          if (ProductQuantity_in == 4'd0) begin
            err_q <= 1'b1;
          end else begin
            lid_q  <= ProductID_in;
            lqty_q <= ProductQuantity_in;
            idx_q  <= '0;
            busy_q <= 1'b1;
`ifdef BASKET_MERGE_EN
            state_q <= (cnt_q == 4'd0) ? APPEND : SEARCH;
`else
            state_q <= APPEND;
`endif
          end
        end
      end else begin
        // Stray pulses while busy are flagged but never disturb the running command
        err_q <= Enable_Pulse | Cancel_Pulse;
        case (state_q)
`ifdef BASKET_MERGE_EN
          SEARCH: begin
            if (id_q[cur] == lid_q) begin
              qty_q[cur] <= clamp(sum);
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else if (idx_q == cnt_q - 4'd1) begin
              state_q <= APPEND;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
`endif
          APPEND: begin
            if (cnt_q < NMAX) begin
              id_q[tail]  <= lid_q;
              qty_q[tail] <= clamp({1'b0, lqty_q});
              cnt_q       <= cnt_q + 4'd1;
              done_q      <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          REMOVE: begin
            if (idx_q == cnt_q - 4'd1) begin
              id_q[cur]  <= '0;
              qty_q[cur] <= '0;
              cnt_q      <= cnt_q - 4'd1;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              id_q[cur]  <= id_q[nxt];
              qty_q[cur] <= qty_q[nxt];
              idx_q      <= idx_q + 4'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign BasketProductNum = cnt_q;
  assign Busy             = busy_q;
  assign Done             = done_q;
  assign Error            = err_q;
  assign Full             = (cnt_q == NMAX);
  assign Read_ProductID   = rd_id_q;
  assign Read_Quantity    = rd_qty_q;
endmodule

// File: tb/tb_basket_controller.sv
// Self-checking bench for basket_controller: directed scenarios plus a random
// command stream, all checked against a queue-based basket model.
module tb_basket_controller;
  logic       CLOCK_50 = 1'b0, RESET_N = 1'b0;
  logic       Enable_Pulse = 1'b0, Cancel_Pulse = 1'b0, Clear_Pulse = 1'b0;
  logic [3:0] ProductID_in = '0, ProductQuantity_in = '0;
  logic [2:0] Read_Index = '0;
  logic [3:0] BasketProductNum, Read_ProductID, Read_Quantity;
  logic       Busy, Done, Error, Full;

  int n_chk = 0, n_pass = 0;
  int m_id[$], m_q[$];

  basket_controller dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
    .Enable_Pulse(Enable_Pulse), .Cancel_Pulse(Cancel_Pulse), .Clear_Pulse(Clear_Pulse),
    .ProductID_in(ProductID_in), .ProductQuantity_in(ProductQuantity_in),
    .Read_Index(Read_Index), .BasketProductNum(BasketProductNum),
    .Busy(Busy), .Done(Done), .Error(Error), .Full(Full),
    .Read_ProductID(Read_ProductID), .Read_Quantity(Read_Quantity)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // ---------------- reference model ----------------
  function automatic void mdl_clear();
    m_id.delete();
    m_q.delete();
  endfunction

  // Add: returns cycles from accept edge to Done/Error, err = rejected
  function automatic int mdl_add(int id, int q, output bit err);
    int lat;
    err = 0;
    if (q == 0) begin
      err = 1;
      return 1;
    end
`ifdef BASKET_MERGE_EN
    begin
      int hit;
      hit = -1;
      for (int i = 0; i < m_id.size(); i++) if (hit < 0 && m_id[i] == id) hit = i;
      if (hit >= 0) begin
        m_q[hit] = (m_q[hit] + q > 15) ? 15 : m_q[hit] + q;
        return 2 + hit;
      end
    end
    lat = 2 + m_id.size();
`else
    lat = 2;
`endif
    if (m_id.size() < 8) begin
      m_id.push_back(id);
      m_q.push_back(q);
    end else err = 1;
    return lat;
  endfunction

  function automatic int mdl_cancel(int k, output bit err);
    int lat;
    err = 0;
    if (k >= m_id.size()) begin
      err = 1;
      return 1;
    end
    lat = m_id.size() - k + 1;
    m_id.delete(k);
    m_q.delete(k);
    return lat;
  endfunction

  // ---------------- stimulus primitives ----------------
  // Called at #1 after an edge; leaves the bench in cycle T+1
  task automatic issue(bit en, bit can, bit clr, int id, int q);
    Enable_Pulse = en; Cancel_Pulse = can; Clear_Pulse = clr;
    ProductID_in = 4'(id); ProductQuantity_in = 4'(q);
    @(posedge CLOCK_50); #1;
    Enable_Pulse = 0; Cancel_Pulse = 0; Clear_Pulse = 0;
  endtask

  // Waits for Done/Error; bb flags Busy low before completion or high at it
  task automatic wait_end(output int lat, output bit d, output bit e, output bit bb);
    lat = 1; bb = 0;
    while (!(Done || Error) && lat < 60) begin
      if (!Busy) bb = 1;
      @(posedge CLOCK_50); #1;
      lat++;
    end
    d = Done; e = Error;
    if (Busy) bb = 1;
  endtask

  task automatic do_add(int id, int q, output int lat, output bit d, output bit e,
                        output bit bb, output int elat, output bit eerr);
    elat = mdl_add(id, q, eerr);
    issue(1, 0, 0, id, q);
    wait_end(lat, d, e, bb);
  endtask

  task automatic do_cancel(int k, output int lat, output bit d, output bit e,
                           output bit bb, output int elat, output bit eerr);
    elat = mdl_cancel(k, eerr);
    issue(0, 1, 0, k, 0);
    wait_end(lat, d, e, bb);
  endtask

  task automatic do_clear(output int lat, output bit d, output bit e, output bit bb);
    mdl_clear();
    issue(0, 0, 1, 0, 0);
    wait_end(lat, d, e, bb);
  endtask

  task automatic rd(int i, output logic [3:0] id, output logic [3:0] q);
    Read_Index = 3'(i);
    @(posedge CLOCK_50); #1;
    id = Read_ProductID; q = Read_Quantity;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET_N = 0; Enable_Pulse = 1; ProductID_in = 4'd3; ProductQuantity_in = 4'd2;
    repeat (3) @(posedge CLOCK_50); #1;
    Enable_Pulse = 0;
    n_chk++; if (BasketProductNum !== 4'd0) $display("FAIL reset_count: got %0d want 0", BasketProductNum); else n_pass++;
    n_chk++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else n_pass++;
    n_chk++; if (Done !== 1'b0) $display("FAIL reset_done: got %b want 0", Done); else n_pass++;
    n_chk++; if (Error !== 1'b0) $display("FAIL reset_error: got %b want 0", Error); else n_pass++;
    n_chk++; if (Full !== 1'b0) $display("FAIL reset_full: got %b want 0", Full); else n_pass++;
    n_chk++; if ({Read_ProductID, Read_Quantity} !== 8'h00) $display("FAIL reset_read: got %0d/%0d want 0/0", Read_ProductID, Read_Quantity); else n_pass++;
    RESET_N = 1;
    @(posedge CLOCK_50); #1;
    mdl_clear();
  endtask

  task automatic test_basic();
    int lat, elat; bit d, e, bb, eerr; logic [3:0] gi, gq;
    do_add(3, 2, lat, d, e, bb, elat, eerr);
    n_chk++; if ({lat, d, e, bb} !== {elat, 1'b1, 1'b0, 1'b0}) $display("FAIL add_3_2: got lat=%0d d=%b e=%b bb=%b want lat=%0d d=1 e=0 bb=0", lat, d, e, bb, elat); else n_pass++;
    do_add(5, 4, lat, d, e, bb, elat, eerr);
    n_chk++; if ({lat, d, e, bb} !== {elat, 1'b1, 1'b0, 1'b0}) $display("FAIL add_5_4: got lat=%0d d=%b e=%b bb=%b want lat=%0d d=1 e=0 bb=0", lat, d, e, bb, elat); else n_pass++;
    n_chk++; if (BasketProductNum !== 4'd2) $display("FAIL basic_count: got %0d want 2", BasketProductNum); else n_pass++;
    rd(0, gi, gq);
    n_chk++; if ({gi, gq} !== {4'd3, 4'd2}) $display("FAIL basic_slot0: got %0d/%0d want 3/2", gi, gq); else n_pass++;
    rd(1, gi, gq);
    n_chk++; if ({gi, gq} !== {4'd5, 4'd4}) $display("FAIL basic_slot1: got %0d/%0d want 5/4", gi, gq); else n_pass++;
    rd(2, gi, gq);
    n_chk++; if ({gi, gq} !== 8'h00) $display("FAIL basic_slot2_empty: got %0d/%0d want 0/0", gi, gq); else n_pass++;
  endtask

`ifdef BASKET_MERGE_EN
  task automatic test_merge();
    int lat, elat; bit d, e, bb, eerr; logic [3:0] gi, gq;
    int expq[4] = '{8, 12, 15, 15};
    for (int r = 0; r < 4; r++) begin
      do_add(5, 4, lat, d, e, bb, elat, eerr);
      n_chk++; if ({lat, d, e, bb} !== {elat, 1'b1, 1'b0, 1'b0}) $display("FAIL merge_op%0d: got lat=%0d d=%b e=%b bb=%b want lat=%0d", r, lat, d, e, bb, elat); else n_pass++;
      rd(1, gi, gq);
      n_chk++; if ({gi, gq} !== {4'd5, 4'(expq[r])}) $display("FAIL merge_qty%0d: got %0d/%0d want 5/%0d", r, gi, gq, expq[r]); else n_pass++;
    end
    n_chk++; if (BasketProductNum !== 4'd2) $display("FAIL merge_count: got %0d want 2", BasketProductNum); else n_pass++;
  endtask
`else
  task automatic test_dup();
    int lat, elat; bit d, e, bb, eerr; logic [3:0] gi, gq;
    do_clear(lat, d, e, bb);
    for (int r = 0; r < 2; r++) begin
      do_add(3, 1, lat, d, e, bb, elat, eerr);
      n_chk++; if ({lat, d, e, bb} !== {elat, 1'b1, 1'b0, 1'b0}) $display("FAIL dup_op%0d: got lat=%0d d=%b e=%b bb=%b want lat=%0d", r, lat, d, e, bb, elat); else n_pass++;
    end
    n_chk++; if (BasketProductNum !== 4'd2) $display("FAIL dup_count: got %0d want 2", BasketProductNum); else n_pass++;
    rd(1, gi, gq);
    n_chk++; if ({gi, gq} !== {4'd3, 4'd1}) $display("FAIL dup_slot1: got %0d/%0d want 3/1", gi, gq); else n_pass++;
  endtask
`endif

  task automatic test_full();
    int lat, elat; bit d, e, bb, eerr; logic [3:0] gi, gq; int ei, eq;
    do_clear(lat, d, e, bb);
    n_chk++; if ({lat, d, e, bb} !== {32'd1, 1'b1, 1'b0, 1'b0}) $display("FAIL full_clear: got lat=%0d d=%b e=%b bb=%b want lat=1 d=1", lat, d, e, bb); else n_pass++;
    for (int i = 1; i <= 8; i++) do_add(i, $urandom_range(1, 4), lat, d, e, bb, elat, eerr);
    n_chk++; if (Full !== 1'b1) $display("FAIL full_flag_after_fill: got %b want 1", Full); else n_pass++;
    do_add(9, 2, lat, d, e, bb, elat, eerr);
    n_chk++; if ({lat, d, e, bb} !== {elat, 1'b0, 1'b1, 1'b0}) $display("FAIL full_add9: got lat=%0d d=%b e=%b bb=%b want lat=%0d d=0 e=1", lat, d, e, bb, elat); else n_pass++;
    n_chk++; if ({Full, BasketProductNum} !== {1'b1, 4'd8}) $display("FAIL full_hold: got full=%b n=%0d want 1/8", Full, BasketProductNum); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      rd(i, gi, gq);
      ei = (i < m_id.size()) ? m_id[i] : 0; eq = (i < m_q.size()) ? m_q[i] : 0;
      n_chk++; if ({gi, gq} !== {4'(ei), 4'(eq)}) $display("FAIL full_slot%0d: got %0d/%0d want %0d/%0d", i, gi, gq, ei, eq); else n_pass++;
    end
  endtask

  task automatic test_cancel();
    int lat, elat; bit d, e, bb, eerr; logic [3:0] gi, gq;
    int expid[4] = '{1, 3, 4, 0};
    do_clear(lat, d, e, bb);
    for (int i = 1; i <= 4; i++) do_add(i, 1, lat, d, e, bb, elat, eerr);
    do_cancel(1, lat, d, e, bb, elat, eerr);
    n_chk++; if ({lat, d, e, bb} !== {32'd4, 1'b1, 1'b0, 1'b0}) $display("FAIL cancel1: got lat=%0d d=%b e=%b bb=%b want lat=4 d=1", lat, d, e, bb); else n_pass++;
    n_chk++; if (BasketProductNum !== 4'd3) $display("FAIL cancel1_count: got %0d want 3", BasketProductNum); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd(i, gi, gq);
      n_chk++; if (gi !== 4'(expid[i])) $display("FAIL cancel1_slot%0d: got %0d want %0d", i, gi, expid[i]); else n_pass++;
    end
    do_cancel(3, lat, d, e, bb, elat, eerr);
    n_chk++; if ({lat, d, e, bb} !== {32'd1, 1'b0, 1'b1, 1'b0}) $display("FAIL cancel_oob: got lat=%0d d=%b e=%b bb=%b want lat=1 e=1", lat, d, e, bb); else n_pass++;
    n_chk++; if (BasketProductNum !== 4'd3) $display("FAIL cancel_oob_count: got %0d want 3", BasketProductNum); else n_pass++;
  endtask

  task automatic test_busy_pulse();
    int lat, elat; bit d, e, bb, eerr; logic [3:0] gi, gq; int ei, eq;
    do_add(6, 2, lat, d, e, bb, elat, eerr);
    elat = mdl_cancel(0, eerr);
    issue(0, 1, 0, 0, 0);
    Enable_Pulse = 1; ProductID_in = 4'd9; ProductQuantity_in = 4'd2;
    @(posedge CLOCK_50); #1;
    Enable_Pulse = 0;
    n_chk++; if ({Error, Done, Busy} !== 3'b101) $display("FAIL busy_pulse_err: got e=%b d=%b busy=%b want 1/0/1", Error, Done, Busy); else n_pass++;
    @(posedge CLOCK_50); #1;
    wait_end(lat, d, e, bb);
    lat = lat + 2;
    n_chk++; if ({lat, d, e, bb} !== {elat, 1'b1, 1'b0, 1'b0}) $display("FAIL busy_pulse_remove: got lat=%0d d=%b e=%b bb=%b want lat=%0d d=1", lat, d, e, bb, elat); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd(i, gi, gq);
      ei = (i < m_id.size()) ? m_id[i] : 0; eq = (i < m_q.size()) ? m_q[i] : 0;
      n_chk++; if ({gi, gq} !== {4'(ei), 4'(eq)}) $display("FAIL busy_pulse_slot%0d: got %0d/%0d want %0d/%0d", i, gi, gq, ei, eq); else n_pass++;
    end
    // Clear one cycle into a new-product add
    issue(1, 0, 0, 12, 1);
    Clear_Pulse = 1;
    @(posedge CLOCK_50); #1;
    Clear_Pulse = 0;
    mdl_clear();
    n_chk++; if ({Done, Error, Busy, BasketProductNum} !== {3'b100, 4'd0}) $display("FAIL clear_midop: got d=%b e=%b busy=%b n=%0d want 1/0/0/0", Done, Error, Busy, BasketProductNum); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      rd(i, gi, gq);
      n_chk++; if ({gi, gq} !== 8'h00) $display("FAIL clear_midop_slot%0d: got %0d/%0d want 0/0", i, gi, gq); else n_pass++;
    end
  endtask

  task automatic test_coincident();
    int lat, elat; bit d, e, bb, eerr;
    do_add(7, 3, lat, d, e, bb, elat, eerr);
    do_add(8, 3, lat, d, e, bb, elat, eerr);
    mdl_clear();
    issue(1, 1, 1, 0, 2);
    wait_end(lat, d, e, bb);
    n_chk++; if ({lat, d, e, bb} !== {32'd1, 1'b1, 1'b1, 1'b0}) $display("FAIL coincident: got lat=%0d d=%b e=%b bb=%b want lat=1 d=1 e=1", lat, d, e, bb); else n_pass++;
    n_chk++; if (BasketProductNum !== 4'd0) $display("FAIL coincident_count: got %0d want 0", BasketProductNum); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, elat; bit d, e, bb, eerr; logic [3:0] gi, gq;
    for (int i = 1; i <= 3; i++) do_add(i, 2, lat, d, e, bb, elat, eerr);
    issue(0, 1, 0, 0, 0);
    RESET_N = 0;
    @(posedge CLOCK_50); #1;
    RESET_N = 1;
    mdl_clear();
    n_chk++; if ({BasketProductNum, Busy, Done, Error} !== 7'd0) $display("FAIL reset_mid: got n=%0d busy=%b d=%b e=%b want all 0", BasketProductNum, Busy, Done, Error); else n_pass++;
    rd(0, gi, gq);
    n_chk++; if ({gi, gq} !== 8'h00) $display("FAIL reset_mid_slot0: got %0d/%0d want 0/0", gi, gq); else n_pass++;
  endtask

  task automatic test_random();
    int lat, elat, r, ei, eq; bit d, e, bb, eerr, ed; logic [3:0] gi, gq;
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_clear(lat, d, e, bb); elat = 1; eerr = 0;
      end else if (r <= 3) do_cancel($urandom_range(0, 8), lat, d, e, bb, elat, eerr);
      else do_add($urandom_range(0, 9), $urandom_range(0, 4), lat, d, e, bb, elat, eerr);
      ed = !eerr;
      n_chk++; if ({lat, d, e, bb} !== {elat, ed, eerr, 1'b0}) $display("FAIL rand_op%0d kind%0d: got lat=%0d d=%b e=%b bb=%b want lat=%0d d=%b e=%b", n, r, lat, d, e, bb, elat, ed, eerr); else n_pass++;
      n_chk++; if ({Full, BasketProductNum} !== {m_id.size() == 8, 4'(m_id.size())}) $display("FAIL rand_count%0d: got full=%b n=%0d want n=%0d", n, Full, BasketProductNum, m_id.size()); else n_pass++;
      if (n % 20 == 19) begin
        for (int i = 0; i < 8; i++) begin
          rd(i, gi, gq);
          ei = (i < m_id.size()) ? m_id[i] : 0; eq = (i < m_q.size()) ? m_q[i] : 0;
          n_chk++; if ({gi, gq} !== {4'(ei), 4'(eq)}) $display("FAIL rand_slot%0d_%0d: got %0d/%0d want %0d/%0d", n, i, gi, gq, ei, eq); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef BASKET_MERGE_EN
    test_merge();
`else
    test_dup();
`endif
    test_full();
    test_cancel();
    test_busy_pulse();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
